// File: rtl/array_unpacked_pkg.sv
// Shared types and helpers for the unpacked-array arbiter and its arbiter core.
package array_unpacked_pkg;

    // Number of requesters sharing the single storage access port.
    localparam int NUM_REQ = 2;

    // Widest entry the init pattern helper can produce.
    localparam int MAX_WB = 64;

    typedef enum logic {
        INIT,
        SERVE
    } state_e;

    // Init pattern: every entry holds its own address, zero-extended.
    function automatic logic [MAX_WB-1:0] init_pattern(input int unsigned a);
        return MAX_WB'(a);
    endfunction

endpackage : array_unpacked_pkg

// File: rtl/array_unpacked_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the requester granted most recently loses the next conflict.
module rr_arb2
    import array_unpacked_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    // Index of the requester that completed the most recent access.
    logic last;

    // Grant selection: a lone requester always wins, a conflict goes to the one that is not last.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt = '0;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    // Remember who was served; reset to 1 so requester 0 wins the first conflict.
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule : rr_arb2

// File: rtl/array_unpacked_arbiter.sv
// Storage controller: initialises a WA x WB unpacked array after reset, then shares its
// single access port between two requesters with round-robin arbitration and 1-cycle reads.
// Entry width is limited to 64 bits by the init pattern helper.
module array_unpacked_arbiter
    import array_unpacked_pkg::*;
#(
    parameter  int WA = 8,
    parameter  int WB = 8,
    localparam int AW = $clog2(WA)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_start,
    output logic                busy,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  we,
    input  logic [2*AW-1:0]     addr,
    input  logic [2*WB-1:0]     wdata,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [NUM_REQ-1:0]  rvalid,
    output logic [WB-1:0]       rdata
);

    logic [WB-1:0]     mem [WA];
    state_e            state;
    logic [AW-1:0]     init_addr;
    logic              init_last;
    logic [MAX_WB-1:0] pattern;

    logic              acc_valid;
    logic              acc_we;
    logic [AW-1:0]     acc_addr;
    logic [WB-1:0]     acc_wdata;
    logic              acc_in_range;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == SERVE),
        .req   (req),
        .gnt   (gnt)
    );

    // Route the granted requester's fields onto the single storage port.
    always_comb begin
        acc_valid    = |gnt;
        acc_we       = gnt[1] ? we[1] : we[0];
        acc_addr     = gnt[1] ? addr[AW +: AW] : addr[0 +: AW];
        acc_wdata    = gnt[1] ? wdata[WB +: WB] : wdata[0 +: WB];
        acc_in_range = 32'(acc_addr) < 32'(WA);
        init_last    = init_addr == AW'(WA - 1);
        pattern      = init_pattern(32'(init_addr));
    end

    // Storage writes: the init pass in INIT, granted in-range writes in SERVE.
    // NOTE: the array has no reset; the init pass gives it defined contents instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_addr] <= pattern[WB-1:0];
        end else if (acc_valid && acc_we && acc_in_range) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    // Control FSM plus the registered read path; busy mirrors the INIT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_addr <= '0;
            busy      <= 1'b1;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            rvalid <= '0;
            if (acc_valid && !acc_we) begin
                rvalid <= gnt;
                rdata  <= acc_in_range ? mem[acc_addr] : '0;
            end

            case (state)
                INIT: begin
                    if (init_last) begin
                        state     <= SERVE;
                        busy      <= 1'b0;
                        init_addr <= '0;
                    end else begin
                        init_addr <= init_addr + AW'(1);
                    end
                end
                SERVE: begin
                    if (init_start) begin
                        state     <= INIT;
                        busy      <= 1'b1;
                        init_addr <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule : array_unpacked_arbiter

// File: tb/tb_array_unpacked_arbiter.sv
// Directed bench: an 8-entry instance for the main behaviour and a 6-entry instance for
// out-of-range addressing. Expected values are hand-computed constants.
module tb_array_unpacked_arbiter;

    localparam int WA  = 8;
    localparam int WB  = 8;
    localparam int AW  = 3;
    localparam int WA6 = 6;
    localparam int AW6 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            init_start;
    logic            busy;
    logic [1:0]      req, we, gnt, rvalid;
    logic [2*AW-1:0] addr;
    logic [2*WB-1:0] wdata;
    logic [WB-1:0]   rdata;

    logic             init_start6;
    logic             busy6;
    logic [1:0]       req6, we6, gnt6, rvalid6;
    logic [2*AW6-1:0] addr6;
    logic [2*WB-1:0]  wdata6;
    logic [WB-1:0]    rdata6;

    int n_checks = 0;
    int n_errors = 0;

    array_unpacked_arbiter #(.WA(WA), .WB(WB)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .busy(busy),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
    );

    array_unpacked_arbiter #(.WA(WA6), .WB(WB)) dut6 (
        .clk(clk), .rst_n(rst_n), .init_start(init_start6), .busy(busy6),
        .req(req6), .we(we6), .addr(addr6), .wdata(wdata6),
        .gnt(gnt6), .rvalid(rvalid6), .rdata(rdata6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single read from requester i; checks the grant, then rvalid/rdata one cycle later.
    task automatic do_read(input int i, input logic [AW-1:0] a, input logic [WB-1:0] exp, input string tag);
        req = '0;
        we  = '0;
        req[i] = 1'b1;
        addr[i*AW +: AW] = a;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'(1) << i);
        tick();
        req = '0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'(1) << i);
        check({tag, "_rdata"}, 32'(rdata), 32'(exp));
    endtask

    // Count cycles until busy falls, with gnt required low while busy; bounded.
    task automatic wait_busy_low(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < 20) begin
            if (gnt !== 2'b00) check({tag, "_gnt_in_init"}, 32'(gnt), 32'(0));
            tick();
            n++;
        end
        check({tag, "_init_cycles"}, n, exp_cycles);
        check({tag, "_busy_low"}, 32'(busy), 32'(0));
    endtask

    // One access on the 6-entry instance from requester 0.
    task automatic access6(input logic w, input logic [AW6-1:0] a, input logic [WB-1:0] d);
        req6 = 2'b01;
        we6  = {1'b0, w};
        addr6[0 +: AW6] = a;
        wdata6[0 +: WB] = d;
        #1;
        check("oor_gnt", 32'(gnt6), 32'(1));
        tick();
        req6 = '0;
        we6  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; init_start = 1'b0; req = 2'b01; we = '0; addr = '0; wdata = '0;
        init_start6 = 1'b0; req6 = '0; we6 = '0; addr6 = '0; wdata6 = '0;

        // Reset values while a request is already pending.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));

        // Init pass: 8 cycles from release, requests ignored.
        rst_n = 1'b1;
        wait_busy_low("init", 8);
        req = '0;

        // Init pattern read back in order from requester 0.
        for (int a = 0; a < WA; a++) do_read(0, AW'(a), WB'(a), $sformatf("pat%0d", a));
        tick();
        check("rvalid_one_cycle", 32'(rvalid), 32'(0));
        check("rdata_hold", 32'(rdata), 32'h07);

        // Requester 1 writes 0xA5 to address 3, then reads it back the next cycle.
        req = 2'b10; we = 2'b10; addr[AW +: AW] = 3'd3; wdata[WB +: WB] = 8'hA5;
        #1;
        check("wr_gnt", 32'(gnt), 32'h2);
        tick();
        check("wr_no_rvalid", 32'(rvalid), 32'(0));
        do_read(1, 3'd3, 8'hA5, "wr_rd");

        // Conflict: both requesters read for 4 cycles; last is 1 so order is 0,1,0,1.
        req = 2'b11; we = 2'b00; addr = {3'd6, 3'd2};
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check($sformatf("rr_rvalid%0d", k), 32'(rvalid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr_rdata%0d", k), 32'(rdata), (k % 2 == 0) ? 32'h2 : 32'h6);
        end
        req = '0;

        // init_start together with a granted read: the read still completes in INIT cycle 0.
        req = 2'b01; we = '0; addr[0 +: AW] = 3'd5; init_start = 1'b1;
        #1;
        check("reinit_gnt", 32'(gnt), 32'h1);
        tick();
        init_start = 1'b0;
        check("reinit_rvalid", 32'(rvalid), 32'h1);
        check("reinit_rdata", 32'(rdata), 32'h05);

        // Held request during INIT is ignored; an init_start mid-pass does not restart it.
        addr[0 +: AW] = 3'd3;
        for (int k = 0; k < 8; k++) begin
            init_start = (k == 3);
            #1;
            check($sformatf("init%0d_busy", k), 32'(busy), 32'(1));
            check($sformatf("init%0d_gnt", k), 32'(gnt), 32'(0));
            tick();
        end
        init_start = 1'b0;
        check("reinit_busy_low", 32'(busy), 32'(0));
        check("reinit_first_gnt", 32'(gnt), 32'h1);
        tick();
        req = '0;
        check("reinit_restored_rvalid", 32'(rvalid), 32'h1);
        check("reinit_restored_rdata", 32'(rdata), 32'h03);

        // Reset at INIT cycle 4: outputs return to reset values at once.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        req = 2'b01;
        for (int k = 0; k < 4; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(1));
        check("midrst_gnt", 32'(gnt), 32'(0));
        check("midrst_rvalid", 32'(rvalid), 32'(0));
        check("midrst_rdata", 32'(rdata), 32'(0));
        tick();
        rst_n = 1'b1;
        wait_busy_low("midrst", 8);
        req = '0;
        for (int a = 0; a < WA; a++) do_read(0, AW'(a), WB'(a), $sformatf("midrst_pat%0d", a));

        // Out-of-range on the 6-entry instance: write to 7 dropped, read of 7 gives 0 with rvalid.
        check("oor_idle", 32'(busy6), 32'(0));
        access6(1'b0, 3'd4, 8'h00);
        check("oor_rd4_rvalid", 32'(rvalid6), 32'h1);
        check("oor_rd4_rdata", 32'(rdata6), 32'h04);
        access6(1'b1, 3'd7, 8'hFF);
        check("oor_wr7_no_rvalid", 32'(rvalid6), 32'(0));
        access6(1'b0, 3'd7, 8'h00);
        check("oor_rd7_rvalid", 32'(rvalid6), 32'h1);
        check("oor_rd7_rdata", 32'(rdata6), 32'h00);
        access6(1'b0, 3'd5, 8'h00);
        check("oor_rd5_rvalid", 32'(rvalid6), 32'h1);
        check("oor_rd5_rdata", 32'(rdata6), 32'h05);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_array_unpacked_arbiter
